// File: rtl/average_calc_pkg.sv
// Shared types for the averaging controller and the datapath bench.
package average_calc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ACCUM = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } avg_state_t;

endpackage

// File: rtl/average_calc_controller_if.sv
// Sample handshake and datapath command bundle for the averaging controller.
interface average_calc_controller_if;

    logic start;
    logic in_valid;
    logic in_ready;
    logic load;
    logic shift;
    logic init_sum;
    logic init_shift;
    logic busy;
    logic done;

    modport master (
        input  start, in_valid,
        output in_ready, load, shift, init_sum, init_shift, busy, done
    );

    modport slave (
        output start, in_valid,
        input  in_ready, load, shift, init_sum, init_shift, busy, done
    );

endinterface

// File: rtl/avg_sample_counter.sv
// Mod-N sample counter with enable, synchronous clear and registered terminal-count flag.
module avg_sample_counter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned CNT_W = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_W'(N - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // tc tracks the next count so it is valid in the same cycle as cnt_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == CNT_W'(N - 1));
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/average_calc_controller.sv
// Averaging controller: start -> init -> collect N samples -> shift -> done.
// Optional abort input enabled by defining AVG_CTRL_ABORT_EN.
module average_calc_controller
    import average_calc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AVG_CTRL_ABORT_EN
    input  logic abort,
`endif
    average_calc_controller_if.master bus
);

    avg_state_t state_q, state_d;
    logic       busy_q, init_q, shift_q, done_q, in_ready_q;
    logic       abort_c, accept_c, tc_c;
    logic       cnt_en_c, cnt_clr_c;

`ifdef AVG_CTRL_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign accept_c = in_ready_q & bus.in_valid & ~abort_c;

    avg_sample_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_c),
        .en_i  (cnt_en_c),
        .tc_o  (tc_c)
    );

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        cnt_en_c  = 1'b0;
        cnt_clr_c = 1'b0;
        case (state_q)
            IDLE:  if (bus.start) state_d = INIT;
            INIT: begin
                state_d   = ACCUM;
                cnt_clr_c = 1'b1;
            end
            ACCUM: begin
                if (accept_c) begin
                    cnt_en_c = 1'b1;
                    if (tc_c) begin
                        state_d   = SHIFT;
                        cnt_clr_c = 1'b1;
                    end
                end
            end
            SHIFT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_c && (state_q == INIT || state_q == ACCUM || state_q == SHIFT)) begin
            state_d   = IDLE;
            cnt_clr_c = 1'b1;
        end
    end

    // Moore outputs registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            init_q     <= 1'b0;
            shift_q    <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            init_q     <= (state_d == INIT);
            shift_q    <= (state_d == SHIFT);
            done_q     <= (state_d == DONE);
            in_ready_q <= (state_d == ACCUM);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.load       = accept_c;
    assign bus.shift      = shift_q & ~abort_c;
    assign bus.init_sum   = init_q;
    assign bus.init_shift = init_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_average_calc_controller.sv
// Directed bench: controller plus a small behavioural datapath (m=8, n=4).
module tb_average_calc_controller;
    import average_calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] inputx;
`ifdef AVG_CTRL_ABORT_EN
    logic       abort;
`endif
    logic [9:0] sum_q, result_q;
    int         n_pass = 0;
    int         n_chk  = 0;

    always #5 clk = ~clk;

    average_calc_controller_if bus();

    average_calc_controller #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AVG_CTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    // Behavioural datapath driven by the controller commands
    always @(posedge clk) begin
        if (!rst_n) begin
            sum_q    <= '0;
            result_q <= '0;
        end else begin
            if (bus.init_sum)    sum_q <= '0;
            else if (bus.load)   sum_q <= sum_q + 10'(inputx);
            if (bus.init_shift)  result_q <= '0;
            else if (bus.shift)  result_q <= sum_q >> 2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // load must never coincide with shift or init commands
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.load === 1'b1)
            chk("load_exclusive", 32'(bus.shift | bus.init_sum | bus.init_shift), 32'd0);
    end

    task automatic do_run(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3,
                          input int stall_at, input int stall_len, input int start_at,
                          input bit hold_start, input int exp_res, input int exp_cyc);
        logic [7:0] s [4];
        int idx, stalled, cyc, shifts;
        bit pulsed;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        idx = 0; stalled = 0; shifts = 0; pulsed = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        chk("init_sum", 32'(bus.init_sum), 32'd1);
        chk("init_shift", 32'(bus.init_shift), 32'd1);
        chk("busy_init", 32'(bus.busy), 32'd1);
        chk("in_ready_init", 32'(bus.in_ready), 32'd0);
        while (bus.done !== 1'b1 && cyc < 60) begin
            bus.start = 1'b0;
            if (bus.in_ready && idx == start_at && !pulsed) begin
                bus.start = 1'b1;
                pulsed    = 1'b1;
            end
            if (bus.in_ready && idx == stall_at && stalled < stall_len) begin
                bus.in_valid = 1'b0;
                stalled++;
            end else begin
                bus.in_valid = bus.in_ready && (idx < 4);
                inputx       = s[(idx < 4) ? idx : 3];
            end
            #1;
            if (bus.load === 1'b1) idx++;
            if (bus.shift === 1'b1) shifts++;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = hold_start;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("loads", 32'(idx), 32'd4);
        chk("shift_count", 32'(shifts), 32'd1);
        chk("result", 32'(result_q), 32'(exp_res));
        step();
        chk("done_cleared", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        inputx       = 8'd5;
`ifdef AVG_CTRL_ABORT_EN
        abort        = 1'b0;
`endif
        // Reset with start asserted
        step();
        step();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_shift", 32'(bus.shift), 32'd0);
        chk("rst_init_sum", 32'(bus.init_sum), 32'd0);
        chk("rst_init_shift", 32'(bus.init_shift), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_load", 32'(bus.load), 32'd0);
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Basic run, no stalls
        do_run(8'd10, 8'd20, 8'd30, 8'd40, -1, 0, -1, 1'b0, 25, 7);
        // Stall three cycles between 2nd and 3rd sample
        do_run(8'd10, 8'd20, 8'd30, 8'd40, 2, 3, -1, 1'b0, 25, 10);
        // Start pulse during ACCUM ignored, start then held into a back-to-back run
        do_run(8'd10, 8'd20, 8'd30, 8'd40, -1, 0, 1, 1'b1, 25, 7);
        do_run(8'd8, 8'd8, 8'd8, 8'd8, -1, 0, -1, 1'b0, 8, 7);

        // Reset after two accepted samples
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.in_valid = 1'b1;
        inputx       = 8'd7;
        step();
        step();
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        step();
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        do_run(8'd4, 8'd4, 8'd4, 8'd4, -1, 0, -1, 1'b0, 4, 7);

`ifdef AVG_CTRL_ABORT_EN
        // Abort after the third sample
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.in_valid = 1'b1;
        inputx       = 8'd9;
        step();
        step();
        step();
        abort = 1'b1;
        #1;
        chk("abort_no_load", 32'(bus.load), 32'd0);
        step();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_shift", 32'(bus.shift), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        step();
        chk("abort_done_late", 32'(bus.done), 32'd0);
        do_run(8'd0, 8'd0, 8'd0, 8'd4, -1, 0, -1, 1'b0, 1, 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
